// File: rtl/fetch_unit.sv
// Instruction fetch stage: walks the ROM from pc and hands words downstream over a valid/ready
// handshake. It halts on a zero end-marker word, and a jump restarts fetching from a new address.
module fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] addrRd,
  input  logic [DATA_W-1:0] dataRd,
  input  logic              jumpEn,
  input  logic [ADDR_W-1:0] jumpAddr,
  output logic [DATA_W-1:0] instrOut,
  output logic              instrValid,
  input  logic              instrReady,
  output logic              halted,
  output logic [7:0]        fetchCount
);

  // state | meaning
  // RUN   | fetching: load a new word whenever the output register is free
  // HALT  | end marker seen; idle until a jump
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] instr_q;
  logic              valid_q;
  logic [7:0]        count_q;

  logic transfer;
  logic load_slot;

  assign transfer  = valid_q & instrReady;
  assign load_slot = (state_q == RUN) & (~valid_q | transfer);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      // A transfer coinciding with a jump still counts as delivered.
      if (transfer && count_q != 8'hFF)
        count_q <= count_q + 8'd1;

      if (jumpEn) begin
        pc_q    <= jumpAddr;
        valid_q <= 1'b0;
        state_q <= RUN;
      end else if (load_slot) begin
        if (dataRd != '0) begin
          instr_q <= dataRd;
          valid_q <= 1'b1;
          pc_q    <= pc_q + 1'b1;
        end else begin
          valid_q <= 1'b0;
          state_q <= HALT;
        end
      end
    end
  end

  assign addrRd     = pc_q;
  assign instrOut   = instr_q;
  assign instrValid = valid_q;
  assign halted     = (state_q == HALT);
  assign fetchCount = count_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, instruction address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, instruction word width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port addrRd  output  ADDR_W  read address to the instruction ROM; equals pc combinationally.
REQ-006 The block SHALL have port dataRd  input  DATA_W  combinational ROM read data for addrRd.
REQ-007 The block SHALL have port jumpEn  input  1  load pc from jumpAddr this edge.
REQ-008 The block SHALL have port jumpAddr  input  ADDR_W  jump target.
REQ-009 The block SHALL have port instrOut  output  DATA_W  registered instruction to the downstream stage.
REQ-010 The block SHALL have port instrValid  output  1  instrOut holds an undelivered instruction.
REQ-011 The block SHALL have port instrReady  input  1  downstream accepts instrOut this edge.
REQ-012 The block SHALL have port halted  output  1  high while the FSM is in HALT.
REQ-013 The block SHALL have port fetchCount  output  8  count of delivered instructions, saturating.

Function
REQ-014 The block SHALL hold a pc register of ADDR_W bits; addrRd SHALL equal pc with no register stage.
REQ-015 The FSM SHALL have two states, RUN and HALT; halted SHALL be 1 only in HALT.
REQ-016 A transfer SHALL occur on an edge where instrValid=1 and instrReady=1.
REQ-017 A load slot SHALL exist on an edge in RUN where instrValid=0 or a transfer occurs.
REQ-018 In a load slot with dataRd != 0: instrOut<=dataRd, instrValid<=1, pc<=pc+1 modulo 2^ADDR_W (8'hFF wraps to 8'h00).
REQ-019 In a load slot with dataRd == 0 (end marker): instrValid<=0, pc unchanged, state<=HALT; the zero word SHALL never appear with instrValid=1.
REQ-020 When instrValid=1 and instrReady=0, instrOut, instrValid and pc SHALL hold their values.
REQ-021 In HALT, instrValid SHALL be 0 and pc SHALL hold; instrReady SHALL be ignored.
REQ-022 jumpEn=1 SHALL take priority over load slots: pc<=jumpAddr, instrValid<=0, state<=RUN, from either state.
REQ-023 On jumpEn=1 with a simultaneous transfer, the transfer SHALL count as delivered; any word not transferred SHALL be discarded.
REQ-024 The first instruction from the jump target SHALL appear with instrValid=1 one edge after the jump edge.
REQ-025 fetchCount SHALL increment by 1 on each transfer and saturate at 8'hFF.
REQ-026 Steady-state throughput with instrReady held 1 SHALL be one instruction per clock.

Reset
REQ-027 While rst_n=0, independent of clk: pc=0, instrOut=0, instrValid=0, state=RUN, halted=0, fetchCount=0.
REQ-028 Reset asserted mid-operation SHALL discard any pending instruction; the first edge after release SHALL be a load slot for address 0.

Verification
REQ-029 Reset release, instrReady=1, ROM words 0x0120,0x0220,0x0420,...,0x8020 at addresses 0-7 and 0 elsewhere -> instrOut sequence 0x0120..0x8020 on 8 consecutive edges, then instrValid=0, halted=1, pc=8, fetchCount=8.
REQ-030 Backpressure: instrReady=0 for 3 cycles while instrOut=0x0420 -> instrOut/pc held; on release the next word 0x0820 follows one edge later, no word lost or repeated.
REQ-031 In HALT at pc=8, pulse jumpEn with jumpAddr=3 -> halted=0, next edge instrOut=0x0820, instrValid=1.
REQ-032 jumpEn with jumpAddr=0 while instrValid=1, instrReady=0, instrOut=0x1020 -> 0x1020 discarded and not counted; next delivered word 0x0120.
REQ-033 ROM returning nonzero at every address, jumpAddr=0xFE -> addresses 0xFE, 0xFF, 0x00 fetched in order (wrap-around); fetchCount saturates at 0xFF after 255+ transfers.
REQ-034 rst_n asserted asynchronously between edges while instrValid=1 -> all outputs reach their reset values immediately, without a clock edge.
